// File: rtl/snapshot_bram_playback_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | snapshot_bram_playback_if                                          |
// | Snapshot BRAM port-A signals plus the valid/ready output stream.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface snapshot_bram_playback_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 10
);
  logic              bram_en_a;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_rd_data;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;

  modport master (
    output bram_en_a, bram_we, bram_addr, dout, dout_valid, dout_last,
    input  bram_rd_data, dout_ready
  );

  modport slave (
    input  bram_en_a, bram_we, bram_addr, dout, dout_valid, dout_last,
    output bram_rd_data, dout_ready
  );
endinterface
`default_nettype wire

// File: rtl/snapshot_bram_playback.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | snapshot_bram_playback                                             |
// | Streams a window of snapshot BRAM port-A words onto a valid/ready  |
// | bus through a credit-gated output FIFO.                            |
// | Option macro: SNAPSHOT_PLAYBACK_LOOP_EN (continuous window replay) |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module snapshot_bram_playback #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W:0]          num_words,
  input  logic                     loop,
  output logic                     busy,
  output logic                     done,
  snapshot_bram_playback_if.master bus
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_remain;
  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [RD_LATENCY-1:0] r_pipe_last;
  logic [DATA_W:0]     r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_done_pulse;

  logic [c_CNT_W-1:0]  w_inflight;
  logic                w_issue;
  logic                w_final_issue;
  logic                w_reload;
  logic                w_push;
  logic                w_pop;
  logic                w_abort;
  logic                w_start_go;
  logic                w_drain_done;
  logic [DATA_W:0]     w_head;

`ifdef SNAPSHOT_PLAYBACK_LOOP_EN
  logic [ADDR_W-1:0]   r_base_addr;
  logic [ADDR_W:0]     r_base_len;
  assign w_reload = w_final_issue && loop;
`else
  logic                w_unused_loop;
  assign w_unused_loop = loop;
  assign w_reload      = 1'b0;
`endif

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + c_CNT_W'(r_pipe_vld[i]);
    end
  end

  // Conservative credit: a pop this cycle is not counted, so the FIFO can never overrun.
  assign w_issue       = (r_state == ST_RUN) && ((r_count + w_inflight) < c_DEPTH);
  assign w_final_issue = w_issue && (r_remain == (ADDR_W+1)'(1));
  assign w_push        = r_pipe_vld[RD_LATENCY-1];
  assign w_pop         = (r_count != '0) && bus.dout_ready;
  assign w_abort       = abort && (r_state != ST_IDLE);
  assign w_start_go    = (r_state == ST_IDLE) && start && !abort;

  always_comb begin
    w_state_nxt  = r_state;
    w_drain_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_go && (num_words != '0)) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_abort)                           w_state_nxt = ST_IDLE;
        else if (w_final_issue && !w_reload)   w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if ((r_count == '0) && (w_inflight == '0)) begin
          w_drain_done = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_remain     <= '0;
      r_pipe_vld   <= '0;
      r_pipe_last  <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_done_pulse <= 1'b0;
`ifdef SNAPSHOT_PLAYBACK_LOOP_EN
      r_base_addr  <= '0;
      r_base_len   <= '0;
`endif
    end else begin
      r_done_pulse <= 1'b0;
      if (w_abort) begin
        // Reads still inside the BRAM are dropped by clearing their valid bits.
        r_pipe_vld   <= '0;
        r_pipe_last  <= '0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
        r_done_pulse <= 1'b1;
      end else begin
        if (w_start_go) begin
          if (num_words == '0) begin
            r_done_pulse <= 1'b1;
          end else begin
            r_addr   <= start_addr;
            r_remain <= num_words;
`ifdef SNAPSHOT_PLAYBACK_LOOP_EN
            r_base_addr <= start_addr;
            r_base_len  <= num_words;
`endif
          end
        end

        if (w_issue) begin
`ifdef SNAPSHOT_PLAYBACK_LOOP_EN
          if (w_reload) begin
            r_addr   <= r_base_addr;
            r_remain <= r_base_len;
          end else begin
            r_addr   <= r_addr + ADDR_W'(1);
            r_remain <= r_remain - (ADDR_W+1)'(1);
          end
`else
          r_addr   <= r_addr + ADDR_W'(1);
          r_remain <= r_remain - (ADDR_W+1)'(1);
`endif
        end

        r_pipe_vld[0]  <= w_issue;
        r_pipe_last[0] <= w_final_issue;
        for (int i = 1; i < RD_LATENCY; i++) begin
          r_pipe_vld[i]  <= r_pipe_vld[i-1];
          r_pipe_last[i] <= r_pipe_last[i-1];
        end

        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_pipe_last[RD_LATENCY-1], bus.bram_rd_data};
  end

  assign w_head         = r_mem[r_rd_ptr];
  assign bus.bram_en_a  = w_issue;
  assign bus.bram_we    = 1'b0;
  assign bus.bram_addr  = r_addr;
  assign bus.dout_valid = (r_count != '0);
  assign bus.dout       = bus.dout_valid ? w_head[DATA_W-1:0] : '0;
  assign bus.dout_last  = bus.dout_valid && w_head[DATA_W];
  assign busy           = (r_state != ST_IDLE);
  assign done           = r_done_pulse || w_drain_done;

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && !w_abort && (r_count == c_DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_snapshot_bram_playback.sv
`timescale 1ns/1ps
`default_nettype none
// tb_snapshot_bram_playback: table-driven and randomized playback windows,
// checked against a queue model built from modular address arithmetic.
module tb_snapshot_bram_playback;
  localparam int DATA_W      = 128;
  localparam int ADDR_W      = 10;
  localparam int RD_LATENCY  = 1;
  localparam int FIFO_DEPTH  = 4;
  localparam int DEPTH_WORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              loop = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W:0]   num_words = '0;
  logic              busy;
  logic              done;

  snapshot_bram_playback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  snapshot_bram_playback #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LATENCY(RD_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .start_addr(start_addr),
    .num_words(num_words), .loop(loop), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // BRAM port-A model, one cycle read latency, word = address
  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] rd_q = '0;
  always @(posedge clk) if (bus.bram_en_a) rd_q <= mem[bus.bram_addr];
  assign bus.bram_rd_data = rd_q;

  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  always begin
    bus.dout_ready = (ready_mode == 0) ? 1'b0 : (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] word_of(input int a);
    return DATA_W'(a % DEPTH_WORDS);
  endfunction

  // Reference model: expected issue addresses and expected stream words
  logic [ADDR_W-1:0] addr_q [$];
  logic [DATA_W:0]   exp_q  [$];

  task automatic load_model(input int s, input int n, input int passes);
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < n; i++) begin
        addr_q.push_back(ADDR_W'((s + i) % DEPTH_WORDS));
        exp_q.push_back({(i == n - 1), word_of(s + i)});
      end
    end
  endtask

  int                issued = 0, accepted = 0, run_acc = 0, n_done = 0, n_en = 0, n_last = 0;
  logic [DATA_W-1:0] first_word = '0, last_word = '0, prev_dout = '0;
  logic              prev_stall = 1'b0, prev_abort = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_abort) begin
        chk("stall_valid", bus.dout_valid, 1);
        chk("stall_data", bus.dout, prev_dout);
      end
      if (bus.bram_en_a) begin
        n_en++;
        chk("credit", (issued - accepted) < FIFO_DEPTH, 1);
        chk("issue_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) chk("issue_addr", bus.bram_addr, addr_q.pop_front());
        issued++;
      end
      if (bus.dout_valid && bus.dout_ready) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("dout", {bus.dout_last, bus.dout}, exp_q.pop_front());
        if (run_acc == 0) first_word = bus.dout;
        if (bus.dout_last) begin
          last_word = bus.dout;
          n_last++;
        end
        accepted++;
        run_acc++;
      end
      if (done) n_done++;
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_dout  = bus.dout;
      prev_abort = abort;
    end
  end

  task automatic clear_run();
    @(posedge clk); #1;
    addr_q.delete(); exp_q.delete();
    issued = 0; accepted = 0; run_acc = 0; n_done = 0; n_en = 0; n_last = 0;
  endtask

  task automatic pulse_start(input int s, input int n);
    @(posedge clk); #1;
    start_addr = ADDR_W'(s); num_words = (ADDR_W+1)'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_window(input int s, input int n, input int mode,
                            input logic [DATA_W-1:0] ef, input logic [DATA_W-1:0] el, input int ec);
    bit ok;
    clear_run();
    ready_mode = mode;
    load_model(s, n, 1);
    pulse_start(s, n);
    wait_done(20000, ok);
    chk("done_seen", ok, 1);
    @(negedge clk); #1;
    chk("word_count", run_acc, ec);
    chk("first_word", first_word, ef);
    chk("last_word", last_word, el);
    chk("last_flags", n_last, 1);
    chk("done_pulses", n_done, 1);
    chk("busy_after", busy, 0);
    chk("model_drained", exp_q.size(), 0);
  endtask

  typedef struct {
    int                s;
    int                n;
    int                mode;
    logic [DATA_W-1:0] exp_first;
    logic [DATA_W-1:0] exp_last;
    int                exp_cnt;
  } vec_t;
  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int s, n;
    vecs[0] = '{'h010,    8, 1, 'h010, 'h017,    8};
    vecs[1] = '{'h3FE,    4, 1, 'h3FE, 'h001,    4};
    vecs[2] = '{'h000, 1024, 2, 'h000, 'h3FF, 1024};
    vecs[3] = '{'h3FF,    1, 2, 'h3FF, 'h3FF,    1};
    vecs[4] = '{'h155,   17, 2, 'h155, 'h165,   17};
    vecs[5] = '{'h3F0,   40, 2, 'h3F0, 'h017,   40};
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = word_of(i);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", bus.bram_en_a, 0);
    chk("rst_we", bus.bram_we, 0);
    chk("rst_addr", bus.bram_addr, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_last", bus.dout_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Latency and back-to-back timing, window 0x10..0x17
    clear_run();
    ready_mode = 1;
    load_model('h010, 8, 1);
    pulse_start('h010, 8);
    @(negedge clk); chk("lat_busy", busy, 1); chk("lat_valid0", bus.dout_valid, 0);
    @(negedge clk); chk("lat_valid1", bus.dout_valid, 0);
    @(negedge clk); chk("lat_valid2", bus.dout_valid, 1); chk("lat_first", bus.dout, 'h010);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); chk("b2b_valid", bus.dout_valid, 1);
    end
    chk("b2b_last", bus.dout_last, 1);
    chk("b2b_done_early", done, 0);
    @(negedge clk); chk("done_timing", done, 1);
    @(negedge clk); chk("done_width", done, 0); chk("busy_drop", busy, 0);

    // Table-driven windows
    for (int v = 0; v < 6; v++)
      run_window(vecs[v].s, vecs[v].n, vecs[v].mode, vecs[v].exp_first, vecs[v].exp_last, vecs[v].exp_cnt);

    // Randomized windows
    for (int r = 0; r < 4; r++) begin
      s = int'($urandom_range(0, DEPTH_WORDS - 1));
      n = int'($urandom_range(1, 60));
      run_window(s, n, 2, word_of(s), word_of(s + n - 1), n);
    end

    // Abort after five accepted words of sixteen
    clear_run();
    ready_mode = 1;
    load_model('h040, 16, 1);
    pulse_start('h040, 16);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (run_acc == 5) begin ok = 1'b1; break; end
    end
    chk("abort_reach5", ok, 1);
    ready_mode = 0;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    addr_q.delete(); exp_q.delete(); issued = 0; accepted = 0;
    @(negedge clk);
    chk("abort_valid", bus.dout_valid, 0);
    chk("abort_en", bus.bram_en_a, 0);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    repeat (4) @(negedge clk);
    #1;
    chk("abort_done_once", n_done, 1);
    chk("abort_accepted", run_acc, 5);
    run_window('h040, 16, 2, 'h040, 'h04F, 16);

    // Zero-length start: done only, no reads
    clear_run();
    pulse_start('h020, 0);
    @(negedge clk); chk("zero_done", done, 1); chk("zero_busy", busy, 0);
    repeat (4) @(negedge clk);
    #1;
    chk("zero_no_read", n_en, 0);
    chk("zero_done_once", n_done, 1);

    // Start while busy is ignored
    clear_run();
    ready_mode = 2;
    load_model('h300, 20, 1);
    pulse_start('h300, 20);
    repeat (3) @(posedge clk);
    #1;
    start_addr = 'h100; num_words = 5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(2000, ok);
    chk("busy_start_done", ok, 1);
    @(negedge clk); #1;
    chk("busy_start_count", run_acc, 20);
    chk("busy_start_last", last_word, 'h313);
    chk("busy_start_done_once", n_done, 1);

    // Asynchronous reset mid-playback
    clear_run();
    ready_mode = 1;
    load_model('h080, 30, 1);
    pulse_start('h080, 30);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_en", bus.bram_en_a, 0);
    chk("arst_addr", bus.bram_addr, 0);
    chk("arst_valid", bus.dout_valid, 0);
    chk("arst_dout", bus.dout, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_done", n_done, 0);
    run_window('h3FD, 6, 1, 'h3FD, 'h002, 6);

`ifdef SNAPSHOT_PLAYBACK_LOOP_EN
    // Continuous replay of 0,1,2 until loop is dropped
    clear_run();
    ready_mode = 2;
    load_model(0, 3, 200);
    loop = 1'b1;
    pulse_start(0, 3);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk); #1;
      if (run_acc >= 20) begin ok = 1'b1; break; end
    end
    chk("loop_progress", ok, 1);
    loop = 1'b0;
    wait_done(500, ok);
    chk("loop_done", ok, 1);
    @(negedge clk); #1;
    chk("loop_whole_passes", run_acc % 3, 0);
    chk("loop_last_word", last_word, 2);
    chk("loop_last_flags", n_last, run_acc / 3);
    chk("loop_done_once", n_done, 1);
    addr_q.delete(); exp_q.delete();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
